step_sequencer: RTL and testbench
=================================

// Module: step_sequencer
// PURPOSE
//  Upstream note source for the oscillator. Steps through a small recorded pattern of 6-bit notes at a selectable tempo.
//  Per step it drives the oscillator counter_top word and a gate for downstream amplitude control.
//  Replaces the free-running button shift register as the oscillator's pitch source on the board top.
// PARAMETERS
//  STEPS      8   pattern length (power of 2, 2..16)
//  MIN_SHIFT  16  step period = 2^(MIN_SHIFT+tempo) clk cycles; set 2 in simulation
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst          in   1   synchronous, active-high reset
//  run          in   1   level; 1 = advance steps, 0 = hold/pause
//  record       in   1   level; 1 = overwrite current step with note_in at step end
//  note_in      in   6   note to record; 0 = rest
//  tempo        in   3   step period select, sampled at each step boundary
//  counter_top  out  17  {2'b0, note, 9'h0}, direct to oscillator counter_top
//  gate         out  1   high for first half of a non-rest step
//  step_idx     out  log2(STEPS)  current step
//  step_tick    out  1   one-cycle pulse at each step boundary
// BEHAVIOUR
//  - Reset: pattern all 0, step_idx=0, counter_top=0, gate=0, step_tick=0; divider loaded with 2^(MIN_SHIFT+tempo)-1.
//  - Divider (tempo_divider): down-counter. When run=1 it decrements every clk. At 0 it pulses tick for one cycle,
//    reloads with 2^(MIN_SHIFT+tempo_latched)-1, and latches tempo in the same cycle.
//  - run=0: divider held at reload value, gate forced 0, step_idx/counter_top held. After run rises, the first tick
//    arrives a full period later.
//  - On tick: if record=1, pattern[step_idx] <= note_in (write applies to the step being left).
//    step_idx <= step_idx+1, wrapping STEPS-1 -> 0. step_tick=1 that cycle, registered coincident with the step_idx change.
//  - Note for new step n = pattern[n] after any same-tick write. Writes to the step being left are not visible
//    until that step recurs.
//  - counter_top/gate update 1 clk after step_tick (registered read).
//    note!=0: counter_top <= {2'b0,note,9'h0}, gate <= 1.
//    note==0 (rest): counter_top holds its previous value, gate <= 0.
//  - gate falls when divider count < reload/2 (half-period, integer floor). Never rises mid-step.
//  - tempo change mid-step: no effect until the next tick.
//  - rst mid-step: all state returns to reset values on the next edge; the pattern is cleared.
//  - Widths: divider counter MIN_SHIFT+8 bits. No arithmetic overflow paths besides the step_idx wrap.
// STRUCTURE
//  - Shared package/header: NOTE_W=6, TOP_W=17, NOTE_SHIFT=9, REST_NOTE=6'd0. The oscillator top uses the same
//    constants for counter_top packing.
//  - One sub-module: tempo_divider (clk, rst, en, tempo -> tick, half). Holds the latched tempo and the
//    down-counter.
//  - Pattern store: STEPS x 6 register array, synchronous write.
// TESTING  (MIN_SHIFT=2, STEPS=8)
//  - Reset, run=0 for 100 clk -> counter_top=0, gate=0, step_idx=0, no step_tick.
//  - run=1, tempo=0 -> step_tick every 4 clk; step_idx 0..7 then wraps to 0.
//  - record=1, note_in=6'h15 for 8 steps, then record=0 -> each step gives counter_top=17'h02A00 one clk after tick;
//    gate high 2 clk of 4.
//  - Record 0 into step 3 -> at step 3 gate stays 0 and counter_top keeps step 2's value.
//  - tempo 0->2 mid-step -> current step still 4 clk; following steps 16 clk, gate high 8 clk.
//  - Assert rst mid-pattern with run=1 -> next clk all outputs 0; replayed pattern is all rests.

Source files
------------

// File: rtl/step_sequencer_pkg.sv
// Shared constants for note/counter_top packing between the step sequencer
// and the oscillator top.
//   NOTE_W     note width
//   TOP_W      oscillator counter_top width
//   NOTE_SHIFT position of the note inside counter_top
//   REST_NOTE  note value meaning "no sound"
package step_sequencer_pkg;

  localparam int NOTE_W     = 6;
  localparam int TOP_W      = 17;
  localparam int NOTE_SHIFT = 9;

  localparam logic [NOTE_W-1:0] REST_NOTE = 6'd0;

  // {2'b0, note, 9'h0}
  function automatic logic [TOP_W-1:0] pack_top(input logic [NOTE_W-1:0] note);
    return {{(TOP_W-NOTE_W-NOTE_SHIFT){1'b0}}, note, {NOTE_SHIFT{1'b0}}};
  endfunction

endpackage

// File: rtl/step_sequencer_tempo_divider.sv
// Tempo divider: down-counter producing one tick per step period of
// 2^(MIN_SHIFT+tempo) clk cycles. Tempo is latched at reset and at each tick,
// so a tempo change only takes effect from the following step.
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset
//   en     1 = count, 0 = hold at the reload value
//   tempo  period select, sampled at reset and on tick
//   tick   one-cycle pulse when the count reaches zero
//   half   count reaches the lower half of the period on the next edge
module step_sequencer_tempo_divider #(
  parameter int MIN_SHIFT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] tempo,
  output logic       tick,
  output logic       half
);

  localparam int CW = MIN_SHIFT + 8;

  function automatic logic [CW-1:0] reload_of(input logic [2:0] t);
    logic [CW-1:0] one;
    one = {{(CW-1){1'b0}}, 1'b1};
    return (one << (MIN_SHIFT + int'(t))) - one;
  endfunction

  logic [2:0]    r_tempo;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_reload;

  assign w_reload = reload_of(r_tempo);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tempo <= tempo;
      r_count <= reload_of(tempo);
    end else if (!en) begin
      r_count <= w_reload;
    end else if (r_count == '0) begin
      r_tempo <= tempo;
      r_count <= reload_of(tempo);
    end else begin
      r_count <= r_count - 1'b1;
    end
  end

  assign tick = en && (r_count == '0);
  // Lookahead by one cycle so a registered gate drops exactly when the
  // count goes below reload/2.
  assign half = (r_count <= (w_reload >> 1));

endmodule

// File: rtl/step_sequencer.sv
// Step sequencer: plays a recorded pattern of STEPS notes at a selectable
// tempo, driving the oscillator counter_top word and an amplitude gate.
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   run          1 = advance steps, 0 = pause (gate forced low)
//   record       1 = overwrite the step being left with note_in
//   note_in      note to record, 0 = rest
//   tempo        step period select, 2^(MIN_SHIFT+tempo) cycles
//   counter_top  {2'b0, note, 9'h0} for the oscillator
//   gate         high for the first half of a non-rest step
//   step_idx     current step
//   step_tick    one-cycle pulse at each step boundary
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int STEPS     = 8,
  parameter int MIN_SHIFT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     record,
  input  logic [NOTE_W-1:0]        note_in,
  input  logic [2:0]               tempo,
  output logic [TOP_W-1:0]         counter_top,
  output logic                     gate,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     step_tick
);

  localparam int IDX_W = $clog2(STEPS);

  logic [NOTE_W-1:0] r_pattern [STEPS];
  logic [IDX_W-1:0]  r_idx;
  logic              r_tick;
  logic [TOP_W-1:0]  r_top;
  logic              r_gate;

  logic              w_tick;
  logic              w_half;
  logic [NOTE_W-1:0] w_note;

  step_sequencer_tempo_divider #(
    .MIN_SHIFT (MIN_SHIFT)
  ) u_tempo_divider (
    .clk   (clk),
    .rst   (rst),
    .en    (run),
    .tempo (tempo),
    .tick  (w_tick),
    .half  (w_half)
  );

  // r_idx already points at the new step when r_tick is high, and the write
  // to the step being left has landed, so this is the post-write note.
  assign w_note = r_pattern[r_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        r_pattern[i] <= '0;
      end
      r_idx  <= '0;
      r_tick <= 1'b0;
      r_top  <= '0;
      r_gate <= 1'b0;
    end else begin
      r_tick <= w_tick;
      if (w_tick) begin
        if (record) begin
          r_pattern[r_idx] <= note_in;
        end
        r_idx <= r_idx + 1'b1;
      end

      if (r_tick && (w_note != REST_NOTE)) begin
        r_top <= pack_top(w_note);
      end

      // Gate only rises on the cycle after a step boundary.
      if (!run) begin
        r_gate <= 1'b0;
      end else if (r_tick) begin
        r_gate <= (w_note != REST_NOTE);
      end else if (w_half) begin
        r_gate <= 1'b0;
      end
    end
  end

  assign counter_top = r_top;
  assign gate        = r_gate;
  assign step_idx    = r_idx;
  assign step_tick   = r_tick;

endmodule

// File: tb/tb_step_sequencer.sv
module tb_step_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        record;
  logic [5:0]  note_in;
  logic [2:0]  tempo;
  logic [16:0] counter_top;
  logic        gate;
  logic [2:0]  step_idx;
  logic        step_tick;

  step_sequencer #(.STEPS(8), .MIN_SHIFT(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .record      (record),
    .note_in     (note_in),
    .tempo       (tempo),
    .counter_top (counter_top),
    .gate        (gate),
    .step_idx    (step_idx),
    .step_tick   (step_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] top;
    logic        gate;
  } exp_t;

  exp_t        q[$];
  logic [5:0]  m_pat [8];
  logic [2:0]  m_idx;
  logic [16:0] m_top;
  logic        cur_gate;
  int          n_cmp  = 0;
  int          n_fail = 0;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_pat[i] = 6'd0;
    m_idx    = 3'd0;
    m_top    = 17'd0;
    cur_gate = 1'b0;
    q.delete();
  endtask

  // Called at the negedge where step_tick is seen high.
  task automatic handle_tick(input logic rec, input logic [5:0] note);
    logic [5:0] nt;
    exp_t e;
    if (rec) m_pat[m_idx] = note;
    m_idx = m_idx + 3'd1;
    n_cmp++;
    if (step_idx !== m_idx) begin
      n_fail++;
      $display("FAIL step_idx got %0d exp %0d", step_idx, m_idx);
    end
    nt = m_pat[m_idx];
    if (nt != 6'd0) m_top = {2'b00, nt, 9'h000};
    e.top    = m_top;
    e.gate   = (nt != 6'd0);
    cur_gate = e.gate;
    q.push_back(e);
  endtask

  task automatic wait_first_tick(input int exp_period);
    int  cyc;
    bit  seen;
    seen = 0;
    cyc  = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (step_tick === 1'b1) begin
        cyc  = n;
        seen = 1;
        break;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL first_tick timeout got none exp tick within 200 clk");
    end else if (cyc != exp_period) begin
      n_fail++;
      $display("FAIL first_tick_period got %0d exp %0d", cyc, exp_period);
    end
  endtask

  // Precondition: at the tick negedge of the step being entered.
  task automatic step(input logic rec, input logic [5:0] note,
                      input int exp_period, input int new_tempo);
    int   cyc, hi, exp_hi;
    bit   seen;
    exp_t e;
    record  = rec;
    note_in = note;
    hi      = 0;
    cyc     = 0;
    seen    = 0;
    exp_hi  = cur_gate ? exp_period / 2 : 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 2 && new_tempo >= 0) tempo = 3'(new_tempo);
      if (n == 1) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_empty got 0 entries exp 1");
        end else begin
          e = q.pop_front();
          n_cmp++;
          if (counter_top !== e.top) begin
            n_fail++;
            $display("FAIL counter_top step %0d got %h exp %h", m_idx, counter_top, e.top);
          end
          n_cmp++;
          if (gate !== e.gate) begin
            n_fail++;
            $display("FAIL gate_rise step %0d got %b exp %b", m_idx, gate, e.gate);
          end
        end
        n_cmp++;
        if (step_tick !== 1'b0) begin
          n_fail++;
          $display("FAIL step_tick_width got %b exp 0", step_tick);
        end
      end
      if (step_tick === 1'b1) begin
        cyc  = n;
        seen = 1;
        break;
      end
      if (gate === 1'b1) hi++;
    end
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL step_timeout got none exp tick within 200 clk");
      return;
    end
    n_cmp++;
    if (cyc != exp_period) begin
      n_fail++;
      $display("FAIL step_period step %0d got %0d exp %0d", m_idx, cyc, exp_period);
    end
    n_cmp++;
    if (hi != exp_hi) begin
      n_fail++;
      $display("FAIL gate_high_cycles step %0d got %0d exp %0d", m_idx, hi, exp_hi);
    end
    handle_tick(rec, note);
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1; run = 1'b0; record = 1'b0; note_in = 6'd0; tempo = 3'd0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (counter_top !== 17'd0 || gate !== 1'b0 || step_idx !== 3'd0 || step_tick !== 1'b0)
        bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_outputs got %0d bad cycles exp 0", bad);
    end
    n_cmp++;
    if (counter_top !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_counter_top got %h exp 0", counter_top);
    end
    n_cmp++;
    if (step_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_step_idx got %0d exp 0", step_idx);
    end
  endtask

  task automatic test_stepping();
    run = 1'b1;
    wait_first_tick(4);
    handle_tick(1'b0, 6'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 6'd0, 4, -1);
  endtask

  task automatic test_record();
    for (int i = 0; i < 8; i++) step(1'b1, 6'h15, 4, -1);
    for (int i = 0; i < 8; i++) step(1'b0, 6'd0, 4, -1);
  endtask

  task automatic test_rest();
    for (int i = 0; i < 8 && m_idx != 3'd3; i++) step(1'b0, 6'd0, 4, -1);
    step(1'b1, 6'd0, 4, -1);
    for (int i = 0; i < 9; i++) step(1'b0, 6'd0, 4, -1);
  endtask

  task automatic test_tempo();
    step(1'b0, 6'd0, 4, 2);
    for (int i = 0; i < 4; i++) step(1'b0, 6'd0, 16, -1);
  endtask

  task automatic test_reset_mid();
    repeat (3) @(negedge clk);
    rst   = 1'b1;
    tempo = 3'd0;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (counter_top !== 17'd0) begin
      n_fail++;
      $display("FAIL midrst_counter_top got %h exp 0", counter_top);
    end
    n_cmp++;
    if (gate !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_gate got %b exp 0", gate);
    end
    n_cmp++;
    if (step_idx !== 3'd0) begin
      n_fail++;
      $display("FAIL midrst_step_idx got %0d exp 0", step_idx);
    end
    n_cmp++;
    if (step_tick !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_step_tick got %b exp 0", step_tick);
    end
    model_reset();
    wait_first_tick(4);
    handle_tick(1'b0, 6'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 6'd0, 4, -1);
  endtask

  initial begin
    test_reset();
    test_stepping();
    test_record();
    test_rest();
    test_tempo();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
